// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port MIPS register file: default geometry,
// architectural register indices and the address-width helper.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_AT   = 1;
   localparam int REG_V0   = 2;
   localparam int REG_A0   = 4;
   localparam int REG_T0   = 8;
   localparam int REG_S0   = 16;
   localparam int REG_GP   = 28;
   localparam int REG_SP   = 29;
   localparam int REG_FP   = 30;
   localparam int REG_RA   = 31;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports,
// issue strobe for the scoreboard and the pending count.
interface regfile_mp_if import regfile_pkg::*; #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
);
   localparam int AW = addr_width(DEPTH);

   logic        [NREAD*AW-1:0]     ReadReg;
   logic signed [NREAD*WIDTH-1:0]  ReadData;
   logic        [NREAD-1:0]        ReadBusy;
   logic        [NWRITE-1:0]       WriteEn;
   logic        [NWRITE*AW-1:0]    WriteReg;
   logic signed [NWRITE*WIDTH-1:0] WriteData;
   logic                           IssueEn;
   logic        [AW-1:0]           IssueReg;
   logic        [AW:0]             PendingCnt;

   modport master (
      output ReadReg, WriteEn, WriteReg, WriteData, IssueEn, IssueReg,
      input  ReadData, ReadBusy, PendingCnt
   );

   modport slave (
      input  ReadReg, WriteEn, WriteReg, WriteData, IssueEn, IssueReg,
      output ReadData, ReadBusy, PendingCnt
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits (issue sets, write clears, issue wins a tie)
// with a registered population count.
module regfile_scoreboard import regfile_pkg::*; #(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NWRITE   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_width(DEPTH)
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic [NWRITE-1:0]      wr_en,
   input  logic [NWRITE*AW-1:0]   wr_addr,
   input  logic                   issue_en,
   input  logic [AW-1:0]          issue_addr,
   output logic [DEPTH-1:0]       pending,
   output logic [AW:0]            pending_cnt
);

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [AW:0]      cnt_q, cnt_d;

   always_comb begin
      pend_d = pend_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j]) pend_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a newly issued producer supersedes the write.
      if (issue_en) pend_d[issue_addr] = 1'b1;
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
      cnt_d = '0;
      for (int r = 0; r < DEPTH; r++) begin
         cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending     = pend_q;
   assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional same-cycle bypass,
// hard-wired zero register and a pending scoreboard for hazard detection.
module regfile_mp import regfile_pkg::*; #(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic         Clk,
   input logic         Rst_n,
   regfile_mp_if.slave bus
);

   localparam int AW = addr_width(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];
   logic [NWRITE-1:0] wr_en;
   logic [AW-1:0]     wr_addr [NWRITE];
   logic [WIDTH-1:0]  wr_data [NWRITE];
   logic [AW-1:0]     rd_addr [NREAD];
   logic [WIDTH-1:0]  rd_data [NREAD];
   logic [NREAD-1:0]  rd_busy;
   logic [DEPTH-1:0]  pending;

   // Gating with reset keeps bypassed write data off the read ports during reset.
   assign wr_en = bus.WriteEn & {NWRITE{Rst_n}};

   genvar gi;
   generate
      for (gi = 0; gi < NWRITE; gi++) begin : g_wr
         assign wr_addr[gi] = bus.WriteReg[gi*AW +: AW];
         assign wr_data[gi] = bus.WriteData[gi*WIDTH +: WIDTH];
      end
      for (gi = 0; gi < NREAD; gi++) begin : g_rd
         assign rd_addr[gi]                     = bus.ReadReg[gi*AW +: AW];
         assign bus.ReadData[gi*WIDTH +: WIDTH] = rd_data[gi];
      end
   endgenerate

   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j] == '0)) mem_d[wr_addr[j]] = wr_data[j];
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NREAD; i++) begin
         rd_data[i] = mem_q[rd_addr[i]];
         rd_busy[i] = pending[rd_addr[i]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NWRITE; j++) begin
               if (wr_en[j] && wr_addr[j] == rd_addr[i]) begin
                  rd_data[i] = wr_data[j];
                  if (!(bus.IssueEn && bus.IssueReg == rd_addr[i])) rd_busy[i] = 1'b0;
               end
            end
         end
         if (ZERO_REG != 0 && rd_addr[i] == '0) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
         end
      end
   end

   assign bus.ReadBusy = rd_busy;

   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .wr_en       (wr_en),
      .wr_addr     (bus.WriteReg),
      .issue_en    (bus.IssueEn),
      .issue_addr  (bus.IssueReg),
      .pending     (pending),
      .pending_cnt (bus.PendingCnt)
   );

   generate
      if (DEPTH == 32) begin : g_dbg
         logic [WIDTH-1:0] zr, at, sp, fp, ra;
         assign zr = mem_q[AW'(REG_ZERO)];
         assign at = mem_q[AW'(REG_AT)];
         assign sp = mem_q[AW'(REG_SP)];
         assign fp = mem_q[AW'(REG_FP)];
         assign ra = mem_q[AW'(REG_RA)];
         a_zr_clean: assert property (@(posedge Clk) disable iff (!Rst_n)
            (ZERO_REG == 0) || (zr == '0));
      end
   endgenerate

   a_rd_known: assert property (@(posedge Clk) disable iff (!Rst_n) !$isunknown(bus.ReadReg));

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS datapath; successor to the single-write, dual-read 32x32 file. Adds configurable width, depth and port counts, asynchronous clear, same-cycle write-to-read bypass and a per-register pending scoreboard, so decode can detect load-use and multi-cycle hazards. Sits between decode (read/issue) and writeback (write).

## Interface
Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- NREAD, 2, read ports (1–4)
- NWRITE, 1, write ports (1–2)
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst_n  in  1  reset; asynchronous, active-low
- ReadReg  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- ReadData  out  NREAD*WIDTH  signed read data, combinational
- ReadBusy  out  NREAD  pending bit of the addressed register, combinational
- WriteEn  in  NWRITE  write enables
- WriteReg  in  NWRITE*AW  write addresses
- WriteData  in  NWRITE*WIDTH  signed write data
- IssueEn  in  1  mark IssueReg pending (producer issued)
- IssueReg  in  AW  destination register of the issued producer
- PendingCnt  out  AW+1  number of registers currently pending, registered

## Operation
- Storage: DEPTH x WIDTH flops; no initial values other than reset.
- Write: on posedge, each enabled port j writes data[WriteReg_j] = WriteData_j. When two ports target the same register, the higher-indexed port wins.
- Read: ReadData_i = 0 if ZERO_REG and ReadReg_i == 0. Otherwise, with BYPASS=1, the matching WriteData of an enabled write port in the same cycle is returned (highest-indexed match). Otherwise data[ReadReg_i] is returned.
- Scoreboard: one pending bit per register.
  - Set on posedge when IssueEn targets that register.
  - Cleared on posedge when any enabled write port targets it.
  - Issue and write to the same register in one cycle: set wins (a new producer supersedes).
  - With ZERO_REG, register 0 never becomes pending.
- ReadBusy_i = pending[ReadReg_i], except that with BYPASS=1 a same-cycle write to that register that does not coincide with an issue to it forces ReadBusy_i to 0.
- PendingCnt: registered population count of the pending bits, updated the same edge as the pending bits.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- X on a ReadReg is a simulation error: an assertion fires; there is no $finish in RTL.

## Timing
- Reset (Rst_n low, asynchronous): all registers 0, all pending 0, PendingCnt 0. ReadData therefore reads 0 and ReadBusy 0 while in reset. Writes and issues are ignored while Rst_n is low.
- Reset deassertion: takes effect on the first posedge with Rst_n high. Reset asserted mid-write discards that write.
- Write latency: visible on ReadData in the same cycle (BYPASS=1) or the cycle after the edge (BYPASS=0).
- Scoreboard latency: issue at edge N makes ReadBusy high from after edge N. The write clearing it is seen in the same cycle via bypass, or after the edge when BYPASS=0.
- Reads have no clock dependence; no negedge logic anywhere.

## Structure
- Package regfile_pkg:
  - default WIDTH/DEPTH constants;
  - MIPS register index constants (REG_ZERO=0, REG_SP=29, REG_RA=31, …);
  - function clog2-based AW helper.
- Sub-module regfile_scoreboard:
  - contains the pending bits, set/clear priority and PendingCnt;
  - parametrised by DEPTH, NWRITE, ZERO_REG.
- Debug name wires (zr…ra) are generated only when DEPTH == 32.

## Test plan
- Reset: hold Rst_n low with random writes -> all ReadData 0, ReadBusy 0, PendingCnt 0; after release, reading r5 returns 0.
- Write/read, BYPASS=0: write r8=32'hDEADBEEF at edge N -> ReadData reads the old value 0 in cycle N and 32'hDEADBEEF from N+1. Write r0=7 -> r0 always reads 0.
- Bypass, BYPASS=1: read r9 while writing r9=-5 in the same cycle -> ReadData=-5 before the edge. Two ports write r9 (3 and 4) -> ReadData=4 and stored value 4.
- Scoreboard: issue r16 at edge 1 -> ReadBusy=1 and PendingCnt=1. Write r16 at edge 3 -> busy 0, count 0. Issue and write r17 in the same cycle -> r17 pending, count 1.
- Async reset mid-operation: r3..r6 pending, assert Rst_n between edges -> PendingCnt 0 immediately and all reads 0.
- Parametric: WIDTH=64, DEPTH=16, NREAD=4, NWRITE=2, ZERO_REG=0 -> r0 is writable (r0=64'h1 reads back), and all four read ports are independent.
